fraction_rounder: RTL and testbench

Pipelined rounding and packing stage directly downstream of the normalizer. It consumes the normalized 49-bit fraction in [xx.xxx…] format, with bit 47 as the hidden one, together with the sign and biased exponent. It rounds to single precision, handles carry-out renormalization, overflow and flush-to-zero, and emits a packed IEEE-754 result and flags. It is a two-stage, valid/ready, full-throughput pipeline feeding the FPU result writeback.

---
 rtl/fpu_pkg.sv | 45 ++++
 rtl/fraction_rounder_if.sv | 31 +++
 rtl/round_decision.sv | 25 ++
 rtl/fraction_rounder.sv | 168 ++++++++++++++++
 tb/tb_fraction_rounder.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the rounding/packing stage.
// Build option: FRACTION_ROUNDER_MODES_EN enables the full set of rounding modes.
package fpu_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rounding_mode_t;

    localparam int EXP_MAX    = 255;
    localparam int MANT_BITS  = 23;
    localparam int FRAC_WIDTH = 49;

    localparam logic [31:0] POS_INF    = 32'h7F80_0000;
    localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

    // Stage-1 payload: everything S2 needs to finish rounding and packing.
    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] sig;
        logic        guard;
        logic        sticky;
        logic        inc;
        logic        special;
        logic [31:0] special_result;
    } s1_t;

    // Stage-2 payload: the packed result and its flags.
    typedef struct packed {
        logic [31:0] result;
        logic        inexact;
        logic        overflow;
        logic        underflow;
    } out_t;

    // Apply a sign to an unsigned packed-float magnitude.
    function automatic logic [31:0] with_sign(input logic s, input logic [31:0] mag);
        return {s, mag[30:0]};
    endfunction

endpackage

// File: rtl/fraction_rounder_if.sv
// Valid/ready bus of the fraction rounder: normalized operand in, packed result out.
interface fraction_rounder_if;
    import fpu_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic                  sign;
    logic [9:0]            exponent;
    logic [FRAC_WIDTH-1:0] normalized_fraction;
    logic [2:0]            rounding_mode;
    logic                  special;
    logic [31:0]           special_result;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           result;
    logic                  inexact;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output in_valid, sign, exponent, normalized_fraction, rounding_mode,
               special, special_result, out_ready,
        input  in_ready, out_valid, result, inexact, overflow, underflow
    );

    modport slave (
        input  in_valid, sign, exponent, normalized_fraction, rounding_mode,
               special, special_result, out_ready,
        output in_ready, out_valid, result, inexact, overflow, underflow
    );
endinterface

// File: rtl/round_decision.sv
// Combinational round-up decision from sign, lsb, guard, sticky and mode.
module round_decision
    import fpu_pkg::*;
(
    input  logic           sign,
    input  logic           lsb,
    input  logic           guard,
    input  logic           sticky,
    input  rounding_mode_t mode,
    output logic           inc
);

    // Increment select; unknown mode codes fall back to round-nearest-even.
    always_comb begin
        inc = guard & (sticky | lsb);
        case (mode)
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & (guard | sticky);
            RUP:     inc = ~sign & (guard | sticky);
            RMM:     inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
    end

endmodule

// File: rtl/fraction_rounder.sv
// Two-stage rounding and packing of a normalized fraction into IEEE-754 single.
// Build option: FRACTION_ROUNDER_MODES_EN enables RTZ/RDN/RUP/RMM; otherwise RNE only.
module fraction_rounder
    import fpu_pkg::*;
(
    input logic              clk,
    input logic              reset,
    fraction_rounder_if.slave bus
);

    logic [FRAC_WIDTH-1:0] frac;
    logic [23:0]           in_sig;
    logic                  in_guard;
    logic                  in_sticky;
    logic                  in_inc;
    rounding_mode_t        in_mode;
    logic                  unused_bits;

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    s1_t  s1_q, s1_d;
    out_t out_q, out_d;
    logic s1_adv, s2_adv;

    assign frac      = bus.normalized_fraction;
    assign in_sig    = frac[47:24];
    assign in_guard  = frac[23];
    assign in_sticky = |frac[22:0];

`ifdef FRACTION_ROUNDER_MODES_EN
    rounding_mode_t s1_mode_q, s1_mode_d;
    assign in_mode = rounding_mode_t'(bus.rounding_mode);
`else
    assign in_mode = RNE;
`endif

    round_decision u_round_decision (
        .sign   (bus.sign),
        .lsb    (in_sig[0]),
        .guard  (in_guard),
        .sticky (in_sticky),
        .mode   (in_mode),
        .inc    (in_inc)
    );

    // Handshake: S2 drains on out_ready, S1 moves whenever S2 makes room.
    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_adv;

    // S1 next state: capture the split operand and the increment decision.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d.sign           = bus.sign;
                s1_d.exp            = bus.exponent;
                s1_d.sig            = in_sig;
                s1_d.guard          = in_guard;
                s1_d.sticky         = in_sticky;
                s1_d.inc            = in_inc;
                s1_d.special        = bus.special;
                s1_d.special_result = bus.special_result;
            end
        end
    end

`ifdef FRACTION_ROUNDER_MODES_EN
    // S1 mode register, only needed to pick the overflow saturation value.
    always_comb begin
        s1_mode_d = s1_mode_q;
        if (s1_adv && bus.in_valid) s1_mode_d = in_mode;
    end

    // Mode flop with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) s1_mode_q <= RNE;
        else       s1_mode_q <= s1_mode_d;
    end
`endif

    logic [24:0]           sum;
    logic                  carry;
    logic [MANT_BITS-1:0]  mant;
    logic signed [10:0]    exp_f;
    logic                  ovf, unf;
    logic [31:0]           ovf_res;

    // S2 datapath: increment, renormalize on carry-out, classify the exponent.
    always_comb begin
        sum   = {1'b0, s1_q.sig} + {24'd0, s1_q.inc};
        carry = sum[24];
        mant  = carry ? '0 : sum[MANT_BITS-1:0];
        exp_f = $signed({s1_q.exp[9], s1_q.exp}) + $signed({10'd0, carry});
        ovf   = exp_f >= 11'(EXP_MAX);
        unf   = !s1_q.sig[23] || (exp_f <= 11'sd0);
    end

    // Overflow saturation: infinity or max finite depending on mode and sign.
    always_comb begin
        ovf_res = with_sign(s1_q.sign, POS_INF);
`ifdef FRACTION_ROUNDER_MODES_EN
        case (s1_mode_q)
            RTZ: ovf_res = with_sign(s1_q.sign, MAX_FINITE);
            RDN: ovf_res = s1_q.sign ? with_sign(1'b1, POS_INF)    : MAX_FINITE;
            RUP: ovf_res = s1_q.sign ? with_sign(1'b1, MAX_FINITE) : POS_INF;
            default: ovf_res = with_sign(s1_q.sign, POS_INF);
        endcase
`endif
    end

    // S2 next state: select special bypass, flush, saturation or rounded value.
    always_comb begin
        s2_valid_d = s2_valid_q;
        out_d      = out_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d = '0;
                if (s1_q.special) begin
                    out_d.result = s1_q.special_result;
                end else if (unf) begin
                    out_d.result    = {s1_q.sign, 31'd0};
                    out_d.underflow = 1'b1;
                    out_d.inexact   = 1'b1;
                end else if (ovf) begin
                    out_d.result   = ovf_res;
                    out_d.overflow = 1'b1;
                    out_d.inexact  = 1'b1;
                end else begin
                    out_d.result  = {s1_q.sign, exp_f[7:0], mant};
                    out_d.inexact = s1_q.guard | s1_q.sticky;
                end
            end
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            out_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            out_q      <= out_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.result    = out_q.result;
    assign bus.inexact   = out_q.inexact;
    assign bus.overflow  = out_q.overflow;
    assign bus.underflow = out_q.underflow;

    // Integer bit 48 is zero after normalization; sum[23] is the hidden bit.
`ifdef FRACTION_ROUNDER_MODES_EN
    assign unused_bits = ^{frac[48], sum[23]};
`else
    assign unused_bits = ^{frac[48], sum[23], bus.rounding_mode};
`endif

endmodule

// File: tb/tb_fraction_rounder.sv
// Directed bench for fraction_rounder: rounding cases, stall streaming, mid-flight reset.
module tb_fraction_rounder;
    import fpu_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    fraction_rounder_if bus ();

    fraction_rounder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    localparam logic [48:0] F_ONE   = 49'h0_8000_0000_0000;
    localparam logic [48:0] F_ALL1  = 49'h0_FFFF_FF80_0000;
    localparam logic [48:0] F_TIE_E = 49'h0_8000_0080_0000;
    localparam logic [48:0] F_TIE_O = 49'h0_8000_0180_0000;
    localparam logic [48:0] F_HALF  = 49'h0_4000_0000_0000;
    localparam logic [48:0] F_1P5   = 49'h0_C000_0000_0000;
    localparam logic [48:0] F_STK   = 49'h0_8000_0000_0001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [9:0] e, input logic [48:0] f,
                         input logic [2:0] m, input logic spc, input logic [31:0] spr);
        bus.sign                = s;
        bus.exponent            = e;
        bus.normalized_fraction = f;
        bus.rounding_mode       = m;
        bus.special             = spc;
        bus.special_result      = spr;
    endtask

    // One isolated transaction with out_ready high; checks latency, result, flags.
    task automatic send_one(input string tag, input logic s, input logic [9:0] e,
                            input logic [48:0] f, input logic [2:0] m, input logic spc,
                            input logic [31:0] spr, input logic [31:0] exp_res,
                            input logic [2:0] exp_flags);
        int k;
        @(negedge clk);
        drive(s, e, f, m, spc, spr);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check({tag, "/early"}, 32'(bus.out_valid), 32'd0);
        k = 0;
        while (!bus.out_valid && k < 8) begin
            @(posedge clk);
            #1 k++;
        end
        check({tag, "/latency"}, 32'(k), 32'd1);
        check({tag, "/result"}, bus.result, exp_res);
        check({tag, "/flags"}, {29'd0, bus.inexact, bus.overflow, bus.underflow}, {29'd0, exp_flags});
        @(posedge clk);
        #1;
    endtask

    logic [48:0] st_f [4];
    logic [9:0]  st_e [4];
    logic        st_s [4];
    logic [31:0] st_r [4];
    logic [31:0] got [$];

    initial begin
        int acc;
        int seen;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 10'd0, '0, 3'd0, 1'b0, 32'd0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst/in_ready", 32'(bus.in_ready), 32'd1);
        check("rst/out_valid", 32'(bus.out_valid), 32'd0);
        check("rst/result", bus.result, 32'd0);
        check("rst/flags", {29'd0, bus.inexact, bus.overflow, bus.underflow}, 32'd0);
        reset = 1'b0;

        // Rounding and packing cases (flags are {inexact, overflow, underflow})
        send_one("one",       1'b0, 10'd127, F_ONE,   3'd0, 1'b0, 32'd0, 32'h3F80_0000, 3'b000);
        send_one("carry",     1'b0, 10'd127, F_ALL1,  3'd0, 1'b0, 32'd0, 32'h4000_0000, 3'b100);
        send_one("tie_even",  1'b0, 10'd127, F_TIE_E, 3'd0, 1'b0, 32'd0, 32'h3F80_0000, 3'b100);
        send_one("tie_odd",   1'b0, 10'd127, F_TIE_O, 3'd0, 1'b0, 32'd0, 32'h3F80_0002, 3'b100);
        send_one("ovf_rne",   1'b0, 10'd254, F_ALL1,  3'd0, 1'b0, 32'd0, 32'h7F80_0000, 3'b110);
        send_one("neg_two",   1'b1, 10'd128, F_ONE,   3'd0, 1'b0, 32'd0, 32'hC000_0000, 3'b000);
        send_one("min_norm",  1'b0, 10'd1,   F_ONE,   3'd0, 1'b0, 32'd0, 32'h0080_0000, 3'b000);
        send_one("max_exp",   1'b0, 10'd254, F_ONE,   3'd0, 1'b0, 32'd0, 32'h7F00_0000, 3'b000);
        send_one("unf_exp0",  1'b1, 10'd0,   F_ONE,   3'd0, 1'b0, 32'd0, 32'h8000_0000, 3'b101);
        send_one("unf_negex", 1'b0, 10'h3FF, F_ONE,   3'd0, 1'b0, 32'd0, 32'h0000_0000, 3'b101);
        send_one("no_hidden", 1'b0, 10'd127, F_HALF,  3'd0, 1'b0, 32'd0, 32'h0000_0000, 3'b101);
        send_one("rnd_to_min",1'b0, 10'd0,   F_ALL1,  3'd0, 1'b0, 32'd0, 32'h0080_0000, 3'b100);
        send_one("special",   1'b0, 10'd127, F_ONE,   3'd0, 1'b1, 32'h7FC0_0000, 32'h7FC0_0000, 3'b000);
        send_one("ovf_neg",   1'b1, 10'd255, F_ONE,   3'd2, 1'b0, 32'd0, 32'hFF80_0000, 3'b110);
`ifdef FRACTION_ROUNDER_MODES_EN
        send_one("rtz_254",   1'b0, 10'd254, F_ALL1,  3'd1, 1'b0, 32'd0, 32'h7F7F_FFFF, 3'b100);
        send_one("rtz_ovf",   1'b1, 10'd255, F_ONE,   3'd1, 1'b0, 32'd0, 32'hFF7F_FFFF, 3'b110);
        send_one("rdn_posov", 1'b0, 10'd255, F_ONE,   3'd2, 1'b0, 32'd0, 32'h7F7F_FFFF, 3'b110);
        send_one("rup_negov", 1'b1, 10'd255, F_ONE,   3'd3, 1'b0, 32'd0, 32'hFF7F_FFFF, 3'b110);
        send_one("rup_pos",   1'b0, 10'd127, F_STK,   3'd3, 1'b0, 32'd0, 32'h3F80_0001, 3'b100);
        send_one("rmm_tie",   1'b0, 10'd127, F_TIE_E, 3'd4, 1'b0, 32'd0, 32'h3F80_0001, 3'b100);
        send_one("bad_mode",  1'b0, 10'd127, F_TIE_O, 3'd6, 1'b0, 32'd0, 32'h3F80_0002, 3'b100);
`else
        send_one("rtz_254",   1'b0, 10'd254, F_ALL1,  3'd1, 1'b0, 32'd0, 32'h7F80_0000, 3'b110);
        send_one("rdn_posov", 1'b0, 10'd255, F_ONE,   3'd2, 1'b0, 32'd0, 32'h7F80_0000, 3'b110);
        send_one("rup_pos",   1'b0, 10'd127, F_STK,   3'd3, 1'b0, 32'd0, 32'h3F80_0000, 3'b100);
        send_one("rmm_tie",   1'b0, 10'd127, F_TIE_E, 3'd4, 1'b0, 32'd0, 32'h3F80_0000, 3'b100);
`endif

        // Streaming: 4 items back-to-back, out_ready low in cycles 3..5
        st_f = '{F_ONE, F_ONE, F_ONE, F_1P5};
        st_e = '{10'd127, 10'd128, 10'd127, 10'd127};
        st_s = '{1'b0, 1'b0, 1'b1, 1'b0};
        st_r = '{32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 32'h3FC0_0000};
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 3 && c <= 5);
            if (acc < 4) begin
                drive(st_s[acc], st_e[acc], st_f[acc], 3'd0, 1'b0, 32'd0);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (c == 2) check("stream/accept_emit", 32'(bus.in_ready), 32'd1);
            if (c == 3) check("stream/in_ready_full", 32'(bus.in_ready), 32'd0);
            if (c >= 3 && c <= 5) begin
                check("stream/stall_valid", 32'(bus.out_valid), 32'd1);
                check("stream/stall_hold", bus.result, 32'h4000_0000);
            end
            if (bus.out_valid && bus.out_ready) got.push_back(bus.result);
            if (bus.in_valid && bus.in_ready) acc++;
        end
        check("stream/count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("stream/item%0d", i), (i < got.size()) ? got[i] : 32'hDEAD_BEEF, st_r[i]);

        // Reset with two items in flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b0, 10'd127, F_ONE, 3'd0, 1'b0, 32'd0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        drive(1'b0, 10'd128, F_ONE, 3'd0, 1'b0, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid/out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid/in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("rst_mid/no_output", 32'(seen), 32'd0);
        send_one("after_rst", 1'b0, 10'd127, F_TIE_O, 3'd0, 1'b0, 32'd0, 32'h3F80_0002, 3'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
